// File: rtl/writeback_arbiter.sv
// Single writer of the 32x32 register file: merges the in-order writeback stream
// with buffered long-latency results, enforcing WAW order and exposing pending writes.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        WbWrite,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  input  logic        LlValid,
  input  logic [4:0]  LlReg,
  input  logic [31:0] LlData,
  output logic        LlReady,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        StallReq,
  input  logic [4:0]  LookupReg1,
  input  logic [4:0]  LookupReg2,
  output logic        LookupHit1,
  output logic        LookupHit2,
  output logic [31:0] LookupData1,
  output logic [31:0] LookupData2
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       fifoReg  [DEPTH];
  logic [31:0]      fifoData [DEPTH];
  logic [DEPTH-1:0] fifoKill;
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [AW:0]      fifoCount;
  logic [7:0]       starveCnt;
  logic [7:0]       starveNext;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             wbWin;
  logic             doPush;
  logic             doPop;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign fifoCount = wrPtr - rdPtr;
  assign LlReady   = !fifoFull;

  assign wbWin  = WbWrite && (WbReg != 5'd0);
  assign doPush = LlValid && LlReady && (LlReg != 5'd0);
  assign doPop  = !wbWin && !fifoEmpty;

  // A non-empty FIFO that is not popped means writeback won this cycle.
  assign starveNext = (fifoEmpty || doPop)               ? 8'd0      :
                      (starveCnt == 8'(STARVE_LIMIT))    ? starveCnt :
                                                           starveCnt + 8'd1;

  // NOTE: payload storage has no reset; an entry is meaningful only between the
  // pointers, and the pointers and kill bits are what reset clears.
  always_ff @(posedge Clk) begin
    if (doPush) begin
      fifoReg[wrPtr[AW-1:0]]  <= LlReg;
      fifoData[wrPtr[AW-1:0]] <= LlData;
    end
  end

  // A same-cycle LL push counts as older than the winning WB write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      fifoKill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (doPush && (wrPtr[AW-1:0] == AW'(i))) begin
          fifoKill[i] <= wbWin && (LlReg == WbReg);
        end else if (wbWin && (fifoReg[i] == WbReg)) begin
          fifoKill[i] <= 1'b1;
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wrPtr         <= '0;
      rdPtr         <= '0;
      starveCnt     <= 8'd0;
      StallReq      <= 1'b0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      starveCnt <= starveNext;
      StallReq  <= (starveNext == 8'(STARVE_LIMIT));
      if (wbWin) begin
        RegWrite      <= 1'b1;
        WriteRegister <= WbReg;
        WriteData     <= WbData;
      end else if (doPop) begin
        RegWrite      <= !fifoKill[rdPtr[AW-1:0]];
        WriteRegister <= fifoReg[rdPtr[AW-1:0]];
        WriteData     <= fifoData[rdPtr[AW-1:0]];
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

  // Oldest-to-youngest scan so the youngest live FIFO match overrides the output register.
  function automatic logic [32:0] lookup(input logic [4:0] qReg);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = '0;
    if (qReg != 5'd0) begin
      if (RegWrite && (WriteRegister == qReg)) res = {1'b1, WriteData};
      for (int k = 0; k < DEPTH; k++) begin
        idx = rdPtr[AW-1:0] + AW'(k);
        if (((AW+1)'(k) < fifoCount) && !fifoKill[idx] && (fifoReg[idx] == qReg)) begin
          res = {1'b1, fifoData[idx]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {LookupHit1, LookupData1} = lookup(LookupReg1);
    {LookupHit2, LookupData2} = lookup(LookupReg2);
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_writeback_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        WbWrite = 1'b0;
  logic [4:0]  WbReg = 5'd0;
  logic [31:0] WbData = 32'd0;
  logic        LlValid = 1'b0;
  logic [4:0]  LlReg = 5'd0;
  logic [31:0] LlData = 32'd0;
  logic        LlReady;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        StallReq;
  logic [4:0]  LookupReg1 = 5'd0;
  logic [4:0]  LookupReg2 = 5'd0;
  logic        LookupHit1;
  logic        LookupHit2;
  logic [31:0] LookupData1;
  logic [31:0] LookupData2;

  int checks = 0;
  int errors = 0;

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clk(Clk), .Rst(Rst),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .LlValid(LlValid), .LlReg(LlReg), .LlData(LlData), .LlReady(LlReady),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .StallReq(StallReq),
    .LookupReg1(LookupReg1), .LookupReg2(LookupReg2),
    .LookupHit1(LookupHit1), .LookupHit2(LookupHit2),
    .LookupData1(LookupData1), .LookupData2(LookupData2)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending long-latency results as a plain queue, oldest first.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    bit          kill;
  } ent_t;

  ent_t        mQ[$];
  bit          mRegWrite = 0;
  logic [4:0]  mWReg = 5'd0;
  logic [31:0] mWData = 32'd0;
  bit          mStall = 0;
  int          mStarve = 0;

  always @(posedge Clk or posedge Rst) begin
    bit   wbWin;
    bit   push;
    bit   wasEmpty;
    bit   popped;
    ent_t e;
    if (Rst) begin
      mQ.delete();
      mRegWrite = 0;
      mWReg     = 5'd0;
      mWData    = 32'd0;
      mStall    = 0;
      mStarve   = 0;
    end else begin
      wbWin    = WbWrite && (WbReg != 5'd0);
      push     = LlValid && (mQ.size() < DEPTH) && (LlReg != 5'd0);
      wasEmpty = (mQ.size() == 0);
      popped   = 0;
      e.r = LlReg;
      e.d = LlData;
      e.kill = 0;
      if (wbWin) begin
        mRegWrite = 1;
        mWReg     = WbReg;
        mWData    = WbData;
        foreach (mQ[j]) if (mQ[j].r == WbReg) mQ[j].kill = 1;
        if (LlReg == WbReg) e.kill = 1;
      end else if (!wasEmpty) begin
        mRegWrite = !mQ[0].kill;
        mWReg     = mQ[0].r;
        mWData    = mQ[0].d;
        void'(mQ.pop_front());
        popped = 1;
      end else begin
        mRegWrite = 0;
      end
      if (push) mQ.push_back(e);
      if (wasEmpty || popped) mStarve = 0;
      else if (mStarve < STARVE_LIMIT) mStarve = mStarve + 1;
      mStall = (mStarve == STARVE_LIMIT);
    end
  end

  function automatic logic [32:0] model_lookup(input logic [4:0] q);
    if (q == 5'd0) return 33'd0;
    for (int i = mQ.size() - 1; i >= 0; i--)
      if (!mQ[i].kill && mQ[i].r == q) return {1'b1, mQ[i].d};
    if (mRegWrite && mWReg == q) return {1'b1, mWData};
    return 33'd0;
  endfunction

  // Compare process: inputs change shortly after the rising edge, so the falling edge is stable.
  always @(negedge Clk) begin
    logic [32:0] l1;
    logic [32:0] l2;
    l1 = model_lookup(LookupReg1);
    l2 = model_lookup(LookupReg2);
    check("cmp RegWrite", 32'(RegWrite), 32'(mRegWrite));
    check("cmp WriteRegister", 32'(WriteRegister), 32'(mWReg));
    check("cmp WriteData", WriteData, mWData);
    check("cmp StallReq", 32'(StallReq), 32'(mStall));
    check("cmp LlReady", 32'(LlReady), 32'(mQ.size() < DEPTH));
    check("cmp LookupHit1", 32'(LookupHit1), 32'(l1[32]));
    check("cmp LookupData1", LookupData1, l1[31:0]);
    check("cmp LookupHit2", 32'(LookupHit2), 32'(l2[32]));
    check("cmp LookupData2", LookupData2, l2[31:0]);
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle_inputs();
    WbWrite = 1'b0;
    WbReg   = 5'd0;
    WbData  = 32'd0;
    LlValid = 1'b0;
    LlReg   = 5'd0;
    LlData  = 32'd0;
  endtask

  initial begin
    logic [4:0] fillRegs [4];
    fillRegs[0] = 5'd12;
    fillRegs[1] = 5'd13;
    fillRegs[2] = 5'd14;
    fillRegs[3] = 5'd11;

    #1 Rst = 1'b1;
    repeat (2) tick();
    check("reset RegWrite", 32'(RegWrite), 32'd0);
    check("reset WriteRegister", 32'(WriteRegister), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset StallReq", 32'(StallReq), 32'd0);
    check("reset LlReady", 32'(LlReady), 32'd1);
    Rst = 1'b0;
    tick();

    // Single pipeline write: visible one edge later, then RegWrite drops.
    WbWrite = 1'b1; WbReg = 5'd8; WbData = 32'h1234;
    tick();
    idle_inputs();
    check("wb1 RegWrite", 32'(RegWrite), 32'd1);
    check("wb1 WriteRegister", 32'(WriteRegister), 32'd8);
    check("wb1 WriteData", WriteData, 32'h1234);
    tick();
    check("wb1 RegWrite low", 32'(RegWrite), 32'd0);

    // Two LL results drain in order; lookup sees reg 10 until its write completes.
    LlValid = 1'b1; LlReg = 5'd9; LlData = 32'hAAAA;
    tick();
    LlReg = 5'd10; LlData = 32'hBBBB;
    tick();
    idle_inputs();
    LookupReg1 = 5'd10;
    #1;
    check("ll pop1 RegWrite", 32'(RegWrite), 32'd1);
    check("ll pop1 WriteRegister", 32'(WriteRegister), 32'd9);
    check("ll pop1 WriteData", WriteData, 32'hAAAA);
    check("ll lookup queued hit", 32'(LookupHit1), 32'd1);
    check("ll lookup queued data", LookupData1, 32'hBBBB);
    tick();
    check("ll pop2 WriteRegister", 32'(WriteRegister), 32'd10);
    check("ll pop2 WriteData", WriteData, 32'hBBBB);
    check("ll lookup outreg data", LookupData1, 32'hBBBB);
    tick();
    check("ll drained RegWrite", 32'(RegWrite), 32'd0);
    check("ll lookup gone", 32'(LookupHit1), 32'd0);

    // WAW: a later WB to reg 9 kills the queued LL result for reg 9.
    LlValid = 1'b1; LlReg = 5'd9; LlData = 32'h1111;
    tick();
    idle_inputs();
    WbWrite = 1'b1; WbReg = 5'd9; WbData = 32'h2222;
    LookupReg1 = 5'd9;
    tick();
    idle_inputs();
    #1;
    check("waw wb RegWrite", 32'(RegWrite), 32'd1);
    check("waw wb WriteData", WriteData, 32'h2222);
    check("waw lookup data", LookupData1, 32'h2222);
    tick();
    check("waw killed pop RegWrite", 32'(RegWrite), 32'd0);
    check("waw lookup after", 32'(LookupHit1), 32'd0);

    // Starvation: fill while WB hammers reg 11 (last LL push to reg 11 is killed).
    WbWrite = 1'b1; WbReg = 5'd11; WbData = 32'h5A5A_0011;
    for (int i = 0; i < 4; i++) begin
      LlValid = 1'b1; LlReg = fillRegs[i]; LlData = 32'hC000 + 32'(i);
      tick();
    end
    LlValid = 1'b0;
    check("fill LlReady full", 32'(LlReady), 32'd0);
    repeat (4) tick();
    check("starve StallReq before limit", 32'(StallReq), 32'd0);
    check("starve LlReady still full", 32'(LlReady), 32'd0);
    tick();
    check("starve StallReq at limit", 32'(StallReq), 32'd1);
    WbWrite = 1'b0;
    tick();
    check("starve pop RegWrite", 32'(RegWrite), 32'd1);
    check("starve pop WriteRegister", 32'(WriteRegister), 32'd12);
    check("starve StallReq cleared", 32'(StallReq), 32'd0);

    // Reset with three entries still queued.
    Rst = 1'b1;
    #1;
    check("midreset RegWrite", 32'(RegWrite), 32'd0);
    check("midreset LlReady", 32'(LlReady), 32'd1);
    check("midreset StallReq", 32'(StallReq), 32'd0);
    tick();
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post reset no write", 32'(RegWrite), 32'd0);
    end

    // Register 0 requests are swallowed.
    LookupReg1 = 5'd0;
    for (int i = 0; i < 6; i++) begin
      WbWrite = 1'b1; WbReg = 5'd0; WbData = 32'hDEAD_0000 + 32'(i);
      LlValid = 1'b1; LlReg = 5'd0; LlData = 32'hBEEF_0000 + 32'(i);
      tick();
      check("r0 RegWrite", 32'(RegWrite), 32'd0);
      check("r0 LlReady", 32'(LlReady), 32'd1);
      check("r0 lookup hit", 32'(LookupHit1), 32'd0);
    end
    idle_inputs();
    tick();

    // Randomized traffic; WB-heavy stretches provoke starvation.
    for (int i = 0; i < 3000; i++) begin
      int wbPct;
      wbPct = ((i / 300) % 2 == 1) ? 95 : 40;
      WbWrite    = mStall ? 1'b0 : ($urandom_range(0, 99) < wbPct);
      WbReg      = 5'($urandom_range(0, 7));
      WbData     = $urandom;
      LlValid    = ($urandom_range(0, 99) < 60);
      LlReg      = 5'($urandom_range(0, 7));
      LlData     = $urandom;
      LookupReg1 = 5'($urandom_range(0, 7));
      LookupReg2 = 5'($urandom_range(0, 7));
      if (i == 1500) Rst = 1'b1;
      if (i == 1502) Rst = 1'b0;
      tick();
    end
    idle_inputs();
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
